// File: rtl/spi_burst_sequencer.sv
// spi_burst_sequencer: round-robin arbiter and burst sequencer that shares
// one 8-bit SPI core among NReq requesters.
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   req_valid/req_ready  burst request handshake (ready is a one-hot grant pulse)
//   req_ss, req_len      per-requester slave index and byte count minus 1
//   tx_data/valid/ready  per-requester tx byte stream (ready is a consume pulse)
//   rx_data, rx_valid    shared rx byte, one-hot qualifier pulse
//   spi_din/start/dout   SPI core data and start interface
//   spi_ready/done_tick  SPI core idle flag and byte-complete pulse
//   spi_ss_n             active-low slave selects
//   busy, grant_id       status: not idle, current/last granted requester
//   err_pulse            out-of-range slave index (or WAIT timeout)
//
// Optional: define SPI_SEQ_TIMEOUT_EN to add a per-byte WAIT watchdog of
// TIMEOUT_CYC clocks that aborts the burst and pulses err_pulse.

module spi_burst_sequencer #(
    parameter int NReq        = 2,
    parameter int NSlave      = 2,
    parameter int SS_W        = 2,
    parameter int LEN_W       = 8,
    parameter int SETUP_CYC   = 4,
    parameter int HOLD_CYC    = 4,
    parameter int TIMEOUT_CYC = 65535,
    localparam int GW = (NReq > 1) ? $clog2(NReq) : 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NReq-1:0]       req_valid,
    output logic [NReq-1:0]       req_ready,
    input  logic [NReq*SS_W-1:0]  req_ss,
    input  logic [NReq*LEN_W-1:0] req_len,
    input  logic [NReq*8-1:0]     tx_data,
    input  logic [NReq-1:0]       tx_valid,
    output logic [NReq-1:0]       tx_ready,
    output logic [7:0]            rx_data,
    output logic [NReq-1:0]       rx_valid,
    output logic [7:0]            spi_din,
    output logic                  spi_start,
    input  logic [7:0]            spi_dout,
    input  logic                  spi_ready,
    input  logic                  spi_done_tick,
    output logic [NSlave-1:0]     spi_ss_n,
    output logic                  busy,
    output logic [GW-1:0]         grant_id,
    output logic                  err_pulse
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOAD,
        WAIT,
        HOLD
    } state_t;

    state_t            state;
    logic [GW-1:0]     g;
    logic [GW-1:0]     rr;
    logic [GW-1:0]     pick;
    logic [GW-1:0]     pj;
    logic              pick_ok;
    logic              ss_bad;
    logic              grant;
    logic              fire;
    logic [LEN_W-1:0]  rem;
    logic [15:0]       cnt;

`ifdef SPI_SEQ_TIMEOUT_EN
    logic [15:0]       tmo;
`else
    logic [31:0]       unused_tmo_cfg;
    assign unused_tmo_cfg = TIMEOUT_CYC;
`endif

    logic [7:0]        txd  [NReq];
    logic [SS_W-1:0]   ssv  [NReq];
    logic [LEN_W-1:0]  lenv [NReq];

    for (genvar i = 0; i < NReq; i++) begin : g_unpack
        assign txd[i]  = tx_data[i*8 +: 8];
        assign ssv[i]  = req_ss[i*SS_W +: SS_W];
        assign lenv[i] = req_len[i*LEN_W +: LEN_W];
    end

    // Out-of-range index decodes to all-high, so no slave is selected.
    function automatic logic [NSlave-1:0] ss_dec(input logic [SS_W-1:0] idx);
        logic [NSlave-1:0] v;
        v = '1;
        for (int k = 0; k < NSlave; k++) begin
            if (int'(idx) == k) v[k] = 1'b0;
        end
        return v;
    endfunction

    // rr holds the highest-priority index for the next grant.
    always_comb begin
        pick    = '0;
        pick_ok = 1'b0;
        pj      = '0;
        for (int i = 0; i < NReq; i++) begin
            pj = GW'((int'(rr) + i) % NReq);
            if (!pick_ok && req_valid[pj]) begin
                pick    = pj;
                pick_ok = 1'b1;
            end
        end
    end

    assign ss_bad = (int'(ssv[pick]) >= NSlave);

    // Grant and release both move ss, so both wait for an idle core.
    assign grant = (state == IDLE) && pick_ok && spi_ready;
    assign fire  = (state == LOAD) && tx_valid[g] && spi_ready;

    always_comb begin
        req_ready = '0;
        tx_ready  = '0;
        if (grant) req_ready[pick] = 1'b1;
        if (fire)  tx_ready[g]     = 1'b1;
    end

    assign spi_start = fire;
    assign spi_din   = fire ? txd[g] : 8'h00;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            spi_ss_n  <= '1;
            rx_data   <= 8'h00;
            rx_valid  <= '0;
            grant_id  <= '0;
            err_pulse <= 1'b0;
            rr        <= '0;
            g         <= '0;
            rem       <= '0;
            cnt       <= '0;
`ifdef SPI_SEQ_TIMEOUT_EN
            tmo       <= '0;
`endif
        end else begin
            rx_valid  <= '0;
            err_pulse <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant) begin
                        g         <= pick;
                        grant_id  <= pick;
                        rr        <= (pick == GW'(NReq - 1)) ? '0
                                                             : pick + GW'(1);
                        rem       <= lenv[pick];
                        spi_ss_n  <= ss_dec(ssv[pick]);
                        err_pulse <= ss_bad;
                        cnt       <= '0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == 16'(SETUP_CYC - 1)) begin
                        cnt   <= '0;
                        state <= LOAD;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                LOAD: begin
                    if (fire) begin
                        state <= WAIT;
`ifdef SPI_SEQ_TIMEOUT_EN
                        tmo   <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (spi_done_tick) begin
                        rx_data     <= spi_dout;
                        rx_valid[g] <= 1'b1;
                        if (rem == '0) begin
                            cnt   <= '0;
                            state <= HOLD;
                        end else begin
                            rem   <= rem - LEN_W'(1);
                            state <= LOAD;
                        end
                    end
`ifdef SPI_SEQ_TIMEOUT_EN
                    // Abort: drop remaining bytes, release ss at once.
                    else if (tmo == 16'(TIMEOUT_CYC - 1)) begin
                        err_pulse <= 1'b1;
                        spi_ss_n  <= '1;
                        state     <= IDLE;
                    end else begin
                        tmo <= tmo + 16'd1;
                    end
`endif
                end
                HOLD: begin
                    if (cnt >= 16'(HOLD_CYC - 1)) begin
                        if (spi_ready) begin
                            spi_ss_n <= '1;
                            state    <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_burst_sequencer.sv
// Scoreboard bench for spi_burst_sequencer: directed bursts against a
// behavioural SPI core (dout = din ^ 5A) and queue-based requesters.

module tb_spi_burst_sequencer;

    localparam int NReq   = 2;
    localparam int NSlave = 2;
    localparam int SS_W   = 2;
    localparam int LEN_W  = 8;

    logic                  clk = 1'b0;
    logic                  resetn;
    logic [NReq-1:0]       req_valid;
    logic [NReq-1:0]       req_ready;
    logic [NReq*SS_W-1:0]  req_ss;
    logic [NReq*LEN_W-1:0] req_len;
    logic [NReq*8-1:0]     tx_data;
    logic [NReq-1:0]       tx_valid;
    logic [NReq-1:0]       tx_ready;
    logic [7:0]            rx_data;
    logic [NReq-1:0]       rx_valid;
    logic [7:0]            spi_din;
    logic                  spi_start;
    logic [7:0]            spi_dout;
    logic                  spi_ready;
    logic                  spi_done_tick;
    logic [NSlave-1:0]     spi_ss_n;
    logic                  busy;
    logic [0:0]            grant_id;
    logic                  err_pulse;

    always #5 clk = ~clk;

    spi_burst_sequencer #(
        .NReq(NReq), .NSlave(NSlave), .SS_W(SS_W), .LEN_W(LEN_W),
        .SETUP_CYC(4), .HOLD_CYC(4), .TIMEOUT_CYC(100)
    ) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_ss(req_ss), .req_len(req_len),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .spi_din(spi_din), .spi_start(spi_start), .spi_dout(spi_dout),
        .spi_ready(spi_ready), .spi_done_tick(spi_done_tick),
        .spi_ss_n(spi_ss_n), .busy(busy), .grant_id(grant_id),
        .err_pulse(err_pulse)
    );

    typedef struct {
        int         id;
        logic [7:0] data;
        logic [1:0] ssn;
    } rx_exp_t;

    typedef struct {
        logic [1:0] ss;
        logic [7:0] len;
    } req_t;

    rx_exp_t    exp_rx[$];
    int         exp_grant[$];
    req_t       reqq[NReq][$];
    logic [7:0] txq[NReq][$];

    int checks = 0;
    int errors = 0;

    int         core_cnt = 0;
    logic [7:0] core_data = 8'h00;
    logic [7:0] lat_din = 8'h00;
    bit         start_seen = 0;
    bit         suppress = 0;
    bit         tx_pend[NReq];
    bit         req_pend[NReq];
    int         err_cnt = 0;
    int         start_cnt = 0;
    logic [1:0] prev_ssn = 2'b11;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_rx(input int id, input logic [7:0] d,
                          input logic [1:0] ssn);
        exp_rx.push_back('{id, d, ssn});
    endtask

    task automatic add_req(input int id, input logic [1:0] ss,
                           input logic [7:0] len);
        exp_grant.push_back(id);
        reqq[id].push_back('{ss, len});
    endtask

    // Requester + SPI core model and output monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (resetn) begin
                spi_done_tick = 1'b0;
                if (start_seen) begin
                    core_cnt   = 4;
                    core_data  = lat_din;
                    spi_ready  = 1'b0;
                    start_seen = 0;
                end else if (core_cnt > 0 && !suppress) begin
                    core_cnt--;
                    if (core_cnt == 0) begin
                        spi_dout      = core_data ^ 8'h5A;
                        spi_done_tick = 1'b1;
                        spi_ready     = 1'b1;
                    end
                end
                for (int i = 0; i < NReq; i++) begin
                    if (tx_pend[i]) begin
                        void'(txq[i].pop_front());
                        tx_pend[i] = 0;
                    end
                    if (req_pend[i]) begin
                        void'(reqq[i].pop_front());
                        req_pend[i] = 0;
                    end
                    tx_valid[i] = (txq[i].size() > 0);
                    tx_data[i*8 +: 8] = tx_valid[i] ? txq[i][0] : 8'h00;
                    req_valid[i] = (reqq[i].size() > 0);
                    req_ss[i*SS_W +: SS_W] =
                        req_valid[i] ? reqq[i][0].ss : 2'b00;
                    req_len[i*LEN_W +: LEN_W] =
                        req_valid[i] ? reqq[i][0].len : 8'h00;
                end
            end
            #1;
            if (resetn) begin
                for (int i = 0; i < NReq; i++) begin
                    if (tx_ready[i])  tx_pend[i]  = 1;
                    if (req_ready[i]) req_pend[i] = 1;
                end
                if (spi_start) begin
                    start_seen = 1;
                    lat_din    = spi_din;
                    start_cnt++;
                end
                if (err_pulse) err_cnt++;
                if (req_ready != '0) begin
                    if (exp_grant.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL grant: got %0h expected none",
                                 req_ready);
                    end else begin
                        chk("grant", 32'(req_ready),
                            32'(1) << exp_grant.pop_front());
                    end
                end
                if (rx_valid != '0) begin
                    if (exp_rx.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rx: got %0h/%0h expected none",
                                 rx_valid, rx_data);
                    end else begin
                        rx_exp_t e;
                        e = exp_rx.pop_front();
                        chk("rx_valid", 32'(rx_valid), 32'(1) << e.id);
                        chk("rx_data", 32'(rx_data), 32'(e.data));
                        chk("rx_ss_n", 32'(spi_ss_n), 32'(e.ssn));
                        chk("rx_grant_id", 32'(grant_id), 32'(e.id));
                        chk("rx_busy", 32'(busy), 32'd1);
                    end
                end
                if (spi_ss_n != prev_ssn) begin
                    chk("ss_gap",
                        32'(prev_ssn != 2'b11 && spi_ss_n != 2'b11), 32'd0);
                    prev_ssn = spi_ss_n;
                end
            end
        end
    end

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((exp_rx.size() != 0 || exp_grant.size() != 0 || busy)
               && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_complete"}, 32'(n < 3000), 32'd1);
    endtask

    task automatic clear_model();
        exp_rx.delete();
        exp_grant.delete();
        for (int i = 0; i < NReq; i++) begin
            reqq[i].delete();
            txq[i].delete();
            tx_pend[i]  = 0;
            req_pend[i] = 0;
        end
        start_seen    = 0;
        core_cnt      = 0;
        suppress      = 0;
        req_valid     = '0;
        tx_valid      = '0;
        tx_data       = '0;
        req_ss        = '0;
        req_len       = '0;
        spi_ready     = 1'b1;
        spi_done_tick = 1'b0;
        prev_ssn      = 2'b11;
    endtask

    initial begin
        int s0;
        int e0;
        int n;
        resetn   = 1'b0;
        spi_dout = 8'h00;
        clear_model();
        repeat (3) @(negedge clk);
        #2;
        chk("rst_ss_n", 32'(spi_ss_n), 32'h3);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        chk("rst_err", 32'(err_pulse), 32'd0);
        chk("rst_start", 32'(spi_start), 32'd0);
        chk("rst_din", 32'(spi_din), 32'd0);
        resetn = 1'b1;

        // Single burst, 3 bytes to slave 1.
        s0 = start_cnt;
        add_rx(0, 8'hFF, 2'b01);
        add_rx(0, 8'h66, 2'b01);
        add_rx(0, 8'h55, 2'b01);
        txq[0].push_back(8'hA5);
        txq[0].push_back(8'h3C);
        txq[0].push_back(8'h0F);
        add_req(0, 2'd1, 8'd2);
        wait_done("single");
        chk("single_starts", 32'(start_cnt - s0), 32'd3);
        chk("single_ss_idle", 32'(spi_ss_n), 32'h3);

        // Round robin: requester 1 has priority after granting 0.
        add_rx(1, 8'h69, 2'b01);
        add_rx(0, 8'h4B, 2'b10);
        add_rx(1, 8'h1E, 2'b01);
        add_rx(0, 8'h78, 2'b10);
        txq[0].push_back(8'h11);
        txq[0].push_back(8'h22);
        txq[1].push_back(8'h33);
        txq[1].push_back(8'h44);
        exp_grant.push_back(1);
        exp_grant.push_back(0);
        exp_grant.push_back(1);
        exp_grant.push_back(0);
        reqq[0].push_back('{2'd0, 8'd0});
        reqq[0].push_back('{2'd0, 8'd0});
        reqq[1].push_back('{2'd1, 8'd0});
        reqq[1].push_back('{2'd1, 8'd0});
        wait_done("rr");

        // tx stall after the first byte.
        s0 = start_cnt;
        add_rx(0, 8'h5B, 2'b10);
        add_rx(0, 8'h58, 2'b10);
        add_rx(0, 8'h59, 2'b10);
        txq[0].push_back(8'h01);
        add_req(0, 2'd0, 8'd2);
        n = 0;
        while ((txq[0].size() != 0 || tx_pend[0]) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("stall_first_byte", 32'(n < 200), 32'd1);
        e0 = start_cnt;
        repeat (20) @(negedge clk);
        #2;
        chk("stall_no_start", 32'(start_cnt - e0), 32'd0);
        chk("stall_ss_low", 32'(spi_ss_n), 32'h2);
        chk("stall_busy", 32'(busy), 32'd1);
        txq[0].push_back(8'h02);
        txq[0].push_back(8'h03);
        wait_done("stall");
        chk("stall_starts", 32'(start_cnt - s0), 32'd3);

        // Out-of-range slave index.
        e0 = err_cnt;
        add_rx(1, 8'h99, 2'b11);
        add_rx(1, 8'h24, 2'b11);
        txq[1].push_back(8'hC3);
        txq[1].push_back(8'h7E);
        add_req(1, 2'd3, 8'd1);
        wait_done("oor");
        chk("oor_err_once", 32'(err_cnt - e0), 32'd1);

        // Reset in WAIT of byte 2.
        add_rx(0, 8'hF0, 2'b01);
        txq[0].push_back(8'hAA);
        txq[0].push_back(8'hBB);
        txq[0].push_back(8'hCC);
        txq[0].push_back(8'hDD);
        add_req(0, 2'd1, 8'd3);
        n = 0;
        while ((exp_rx.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("mid_first_byte", 32'(n < 200), 32'd1);
        repeat (3) @(negedge clk);
        #2;
        chk("mid_busy_before", 32'(busy), 32'd1);
        chk("mid_ss_before", 32'(spi_ss_n), 32'h1);
        resetn = 1'b0;
        clear_model();
        #1;
        chk("mid_rst_ss_n", 32'(spi_ss_n), 32'h3);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_grant_id", 32'(grant_id), 32'd0);
        repeat (2) @(negedge clk);
        #2;
        resetn = 1'b1;

        // After reset requester 0 wins first again.
        add_rx(0, 8'h00, 2'b10);
        add_rx(1, 8'hFF, 2'b01);
        txq[0].push_back(8'h5A);
        txq[1].push_back(8'hA5);
        exp_grant.push_back(0);
        exp_grant.push_back(1);
        reqq[0].push_back('{2'd0, 8'd0});
        reqq[1].push_back('{2'd1, 8'd0});
        wait_done("post_reset");

`ifdef SPI_SEQ_TIMEOUT_EN
        // Suppressed done_tick: watchdog aborts after 100 WAIT cycles.
        suppress = 1;
        s0 = start_cnt;
        e0 = err_cnt;
        txq[0].push_back(8'h12);
        txq[0].push_back(8'h34);
        add_req(0, 2'd0, 8'd1);
        n = 0;
        while (start_cnt == s0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_started", 32'(n < 200), 32'd1);
        n = 0;
        while (err_cnt == e0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_cycles", 32'(n), 32'd101);
        #2;
        chk("tmo_busy", 32'(busy), 32'd0);
        chk("tmo_ss_n", 32'(spi_ss_n), 32'h3);
        txq[0].delete();
        core_cnt  = 0;
        spi_ready = 1'b1;
        suppress  = 0;
        repeat (5) @(negedge clk);
`endif

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
